// File: rtl/obd_uart_responder.sv
// OBD PID responder: UART request in, framed telemetry / ESS alert out. Frame start <= 3 clks after request stop sample.
// No backpressure or queue: a request arriving while busy is dropped (req_overrun); alerts are always held until sent.
module obd_uart_responder #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic [7:0]  speed,
    input  logic [13:0] rpm,
    input  logic [7:0]  fuel,
    input  logic [7:0]  temp,
    input  logic [31:0] odometer_raw,
    input  logic        ess_trigger,
    output logic        uart_tx,
    output logic        busy,
    output logic        rx_err,
    output logic        req_overrun
);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] STOP_LAST = 16'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, LOAD, START, DATA, STOP, NEXT} tx_state_t;

    rx_state_t   rx_state_q, rx_state_d;
    tx_state_t   tx_state_q, tx_state_d;
    logic        rx_sync1_q, rx_sync2_q;
    logic [15:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  chk_q, chk_d;
    logic        alert_frm_q, alert_frm_d, tx_q, tx_d;
    logic        req_pending_q, req_pending_d, alert_pending_q, alert_pending_d;
    logic        ess_q, rx_err_q, rx_err_d, req_overrun_q, req_overrun_d;
    logic [7:0]  pid_q, pid_d, speed_s_q, speed_s_d, fuel_s_q, fuel_s_d, temp_s_q, temp_s_d;
    logic [13:0] rpm_s_q, rpm_s_d;
    logic [31:0] odo_s_q, odo_s_d;

    logic        req_valid, accept, ess_edge, take_alert, take_req, do_arb, do_load, supported;
    logic [2:0]  frame_len;
    logic [7:0]  data_byte, cur_byte;

    assign uart_tx     = tx_q;
    assign rx_err      = rx_err_q;
    assign req_overrun = req_overrun_q;
    assign busy        = alert_pending_q | req_pending_q | (tx_state_q != TX_IDLE);

    // Receiver: each sample point lands mid-bit, the sync delay being absorbed by the half-bit wait.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        req_valid  = 1'b0;
        rx_err_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rx_sync2_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = '0;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
            end else rx_cnt_d = rx_cnt_q + 16'd1;
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end else rx_cnt_d = rx_cnt_q + 16'd1;
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                if (rx_sync2_q) begin
                    req_valid  = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_err_d   = 1'b1;
                    rx_state_d = RX_WAIT;
                end
            end else rx_cnt_d = rx_cnt_q + 16'd1;
            RX_WAIT: if (rx_sync2_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame byte selection; the last byte of every frame is the running checksum.
    always_comb begin
        data_byte = 8'h12;
        supported = 1'b1;
        frame_len = 3'd4;
        case (pid_q)
            8'h0D: data_byte = speed_s_q;
            8'h0C: begin
                data_byte = (idx_q == 3'd2) ? {2'b00, rpm_s_q[13:8]} : rpm_s_q[7:0];
                frame_len = 3'd5;
            end
            8'h2F: data_byte = fuel_s_q;
            8'h05: data_byte = temp_s_q;
            8'hA6: begin
                frame_len = 3'd7;
                case (idx_q)
                    3'd2:    data_byte = odo_s_q[31:24];
                    3'd3:    data_byte = odo_s_q[23:16];
                    3'd4:    data_byte = odo_s_q[15:8];
                    default: data_byte = odo_s_q[7:0];
                endcase
            end
            default: supported = 1'b0;
        endcase
        if (alert_frm_q) frame_len = 3'd3;
        if (idx_q == frame_len - 3'd1) cur_byte = chk_q;
        else if (alert_frm_q)          cur_byte = (idx_q == 3'd0) ? 8'h62 : 8'h01;
        else if (idx_q == 3'd0)        cur_byte = supported ? 8'h41 : 8'h7F;
        else if (idx_q == 3'd1)        cur_byte = pid_q;
        else                           cur_byte = data_byte;
    end

    // Transmitter: NEXT is the final clock of each stop bit, so bytes stay back-to-back.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        alert_frm_d = alert_frm_q;
        take_alert  = 1'b0;
        take_req    = 1'b0;
        do_arb      = 1'b0;
        do_load     = 1'b0;
        case (tx_state_q)
            TX_IDLE: do_arb  = 1'b1;
            LOAD:    do_load = 1'b1;
            START: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = DATA;
            end else tx_cnt_d = tx_cnt_q + 16'd1;
            DATA: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b1, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = STOP;
            end else tx_cnt_d = tx_cnt_q + 16'd1;
            STOP: if (tx_cnt_q == STOP_LAST) tx_state_d = NEXT;
                  else tx_cnt_d = tx_cnt_q + 16'd1;
            NEXT: if (idx_q < frame_len) do_load = 1'b1;
                  else do_arb = 1'b1;
            default: tx_state_d = TX_IDLE;
        endcase
        if (do_load) begin
            tx_shift_d = cur_byte;
            chk_d      = chk_q + cur_byte;
            idx_d      = idx_q + 3'd1;
            tx_cnt_d   = '0;
            tx_state_d = START;
        end
        if (do_arb) begin
            tx_state_d = TX_IDLE;
            idx_d      = '0;
            chk_d      = '0;
            if (alert_pending_q) begin
                take_alert  = 1'b1;
                alert_frm_d = 1'b1;
                tx_state_d  = LOAD;
            end else if (req_pending_q) begin
                take_req    = 1'b1;
                alert_frm_d = 1'b0;
                tx_state_d  = LOAD;
            end
        end
        if (tx_state_d == START)     tx_d = 1'b0;
        else if (tx_state_d == DATA) tx_d = tx_shift_d[0];
        else                         tx_d = 1'b1;
    end

    always_comb begin
        ess_edge        = ess_trigger & ~ess_q;
        accept          = req_valid & (tx_state_q == TX_IDLE) & ~req_pending_q & ~alert_pending_q;
        req_overrun_d   = req_valid & ~accept;
        req_pending_d   = (req_pending_q & ~take_req) | accept;
        alert_pending_d = (alert_pending_q & ~take_alert) | ess_edge;
        pid_d     = accept ? rx_shift_q   : pid_q;
        speed_s_d = accept ? speed        : speed_s_q;
        rpm_s_d   = accept ? rpm          : rpm_s_q;
        fuel_s_d  = accept ? fuel         : fuel_s_q;
        temp_s_d  = accept ? temp         : temp_s_q;
        odo_s_d   = accept ? odometer_raw : odo_s_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync1_q <= 1'b1;  rx_sync2_q <= 1'b1;
            rx_state_q <= RX_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_shift_q <= '0;
            tx_state_q <= TX_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0; tx_shift_q <= '0;
            idx_q <= '0; chk_q <= '0; alert_frm_q <= 1'b0; tx_q <= 1'b1;
            req_pending_q <= 1'b0; alert_pending_q <= 1'b0; ess_q <= 1'b0;
            rx_err_q <= 1'b0; req_overrun_q <= 1'b0;
            pid_q <= '0; speed_s_q <= '0; rpm_s_q <= '0; fuel_s_q <= '0; temp_s_q <= '0; odo_s_q <= '0;
        end else begin
            rx_sync1_q <= uart_rx; rx_sync2_q <= rx_sync1_q;
            rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_shift_q <= rx_shift_d;
            tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d; tx_shift_q <= tx_shift_d;
            idx_q <= idx_d; chk_q <= chk_d; alert_frm_q <= alert_frm_d; tx_q <= tx_d;
            req_pending_q <= req_pending_d; alert_pending_q <= alert_pending_d; ess_q <= ess_trigger;
            rx_err_q <= rx_err_d; req_overrun_q <= req_overrun_d;
            pid_q <= pid_d; speed_s_q <= speed_s_d; rpm_s_q <= rpm_s_d;
            fuel_s_q <= fuel_s_d; temp_s_q <= temp_s_d; odo_s_q <= odo_s_d;
        end
    end
endmodule

// File: doc/obd_uart_responder.md
Name: obd_uart_responder

Overview:
- OBD-style diagnostic responder for the vehicle telemetry bus: receives single-byte PID requests from an external tester over UART and returns framed telemetry (speed, rpm, fuel, temp, odometer).
- Also emits an unsolicited alert frame when the emergency-stop signal (ess_trigger) asserts.
- Sits between the vehicle logic outputs and the board UART pins. All logic runs in the vehicle clock domain; the only asynchronous input is uart_rx.

Parameters:
CLKS_PER_BIT, 434, clocks per UART bit (50 MHz / 115200); must be >= 4; benches may override with a small value.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
uart_rx  in  1  request line, 8N1, LSB first, idle high
speed  in  8  vehicle speed
rpm  in  14  engine rpm
fuel  in  8  fuel level
temp  in  8  coolant temperature
odometer_raw  in  32  odometer accumulator
ess_trigger  in  1  emergency-stop level from vehicle logic
uart_tx  out  1  response line, 8N1, LSB first, idle high
busy  out  1  high while a frame is queued or transmitting
rx_err  out  1  one-clock pulse on a framing error
req_overrun  out  1  one-clock pulse when a request is dropped

Behaviour:
Reset (rst low) is asynchronous and can occur at any point, including mid-byte or mid-frame. It forces the following, and a partial frame is abandoned:
- uart_tx=1, busy=0, rx_err=0, req_overrun=0.
- All FSMs return to IDLE.
- pending flags and ESS edge register cleared.

RX:
- uart_rx passes through a 2-FF synchronizer.
- Falling edge in RX_IDLE starts RX_START; the line is re-checked at CLKS_PER_BIT/2. If high, the event is a false start and RX returns to RX_IDLE.
- Otherwise the receiver samples 8 data bits, then the stop bit, each at bit centre.
- Stop bit 0: byte discarded, rx_err pulses, RX waits for the line to go high before re-arming.
- A valid byte produces a one-clock req_valid internally.

Request acceptance:
- If the TX FSM is idle and no frame is pending, req_valid latches the PID and snapshots all telemetry inputs in the same clock, so the frame is coherent.
- Otherwise the request is dropped and req_overrun pulses.
- No request queue.

Frames (all bytes transmitted back-to-back, no idle bits between bytes):
- Supported PIDs: 0x41, PID, data, CHK.
  - 0x0D speed: 1 byte.
  - 0x0C rpm: 2 bytes, big-endian, zero-extended to 16 bits.
  - 0x2F fuel: 1 byte.
  - 0x05 temp: 1 byte.
  - 0xA6 odometer: 4 bytes, big-endian.
- Any other PID: 0x7F, PID, 0x12, CHK.
- Alert frame: 0x62, 0x01, CHK.
- CHK = 8-bit modulo-256 sum of all preceding bytes in the frame.

ESS:
- A rising edge of ess_trigger (registered previous value) sets alert_pending. A level held high does not retrigger.
- Alert frames never overrun and are never dropped.

TX FSM:
- States: TX_IDLE, LOAD, START, DATA, STOP, NEXT.
- Arbitration in TX_IDLE: alert_pending first, then req_pending.
- The frame start bit begins no later than 3 clocks after the request stop-bit sample.
- After the final stop bit, the FSM returns to TX_IDLE and re-arbitrates the same cycle.
- Two frames are therefore separated by exactly 0 or 1 idle clocks, never a partial bit.

busy:
- = alert_pending OR req_pending OR (TX FSM not in TX_IDLE).

Simultaneous events:
- ESS edge and req_valid in the same clock: both accepted, alert sent first.
- ESS edge mid-frame: alert sent after the current frame completes.

Test Plan:
- CLKS_PER_BIT=8, speed=0x3C, request 0x0D → uart_tx sends 41 0D 3C 8A, then holds 1; busy drops after the last stop bit.
- rpm=3000, request 0x0C → 41 0C 0B B8 10. Changing rpm to 5000 mid-frame does not alter the bytes.
- odometer_raw=0x00012345, request 0xA6 → 41 A6 00 01 23 45 50.
- Request 0x99 → 7F 99 12 2A. Then send 0x2F while that frame is in flight → req_overrun pulses once and no second frame is sent.
- ess_trigger rises during the 0x0D frame and stays high 1000 clocks → exactly one 62 01 63 frame, immediately following 8A.
- Stop bit forced to 0 → rx_err pulses, no TX activity. Assert rst mid-frame → uart_tx=1 and busy=0 asynchronously; a new request after release gets a clean frame.
